// File: rtl/hamming_byte_seq_arb.sv
// Purpose: two-requester round-robin byte front end for the 4-bit Hamming encoder;
//          each accepted byte is emitted as two tagged codewords, low nibble first.
// Latency: byte accepted at edge N -> low codeword valid in cycle N+1, high in N+2 (out_ready high).
// Backpressure: outputs held stable while out_valid & !out_ready; requesters stall via reqN_ready.
// Ports: clk, rst_n (sync, active-low); req0/req1 valid/data/ready (byte inputs);
//        out_valid/out_data/out_src/out_last/out_ready (codeword stream); busy (state != IDLE).
// Option: HAMENC_SEQ_ERRINJ_EN adds inj_valid/inj_pos for one-shot single-bit error injection.
module hamming_byte_seq_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_src,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
`ifdef HAMENC_SEQ_ERRINJ_EN
  ,
  input  logic       inj_valid,
  input  logic [2:0] inj_pos
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_hi_nib;
  logic [7:0] r_out_data;
  logic       r_out_src;
  logic       r_out_last;
  logic       r_last_src;

  logic       w_any;
  logic       w_grant;
  logic [7:0] w_sel;
  logic       w_accept_cond;
  logic       w_accept;
  logic       w_load_hi;
  logic [7:0] w_flip;

  function automatic logic [7:0] enc(input logic [3:0] d);
    enc = {d[0] ^ d[1] ^ d[2] ^ d[3],
           d[1] ^ d[2] ^ d[3],
           d[0] ^ d[1] ^ d[3],
           d[3],
           d[0] ^ d[1] ^ d[2],
           d[2], d[1], d[0]};
  endfunction

  // Tie goes to whichever requester did not supply the previous byte.
  assign w_any   = req0_valid | req1_valid;
  assign w_grant = (req0_valid & req1_valid) ? ~r_last_src : req1_valid;
  assign w_sel   = w_grant ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept_cond = 1'b0;
    w_load_hi     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept_cond = 1'b1;
        if (w_any) w_next = S_LO;
      end
      S_LO: begin
        if (out_ready) begin
          w_load_hi = 1'b1;
          w_next    = S_HI;
        end
      end
      S_HI: begin
        // Accepting while the high codeword drains avoids an IDLE bubble.
        if (out_ready) begin
          w_accept_cond = 1'b1;
          w_next        = w_any ? S_LO : S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept   = w_accept_cond & w_any;
  assign req0_ready = w_accept_cond & ~w_grant & req0_valid;
  assign req1_ready = w_accept_cond &  w_grant & req1_valid;

`ifdef HAMENC_SEQ_ERRINJ_EN
  logic       r_inj_pend;
  logic [2:0] r_inj_pos;

  assign w_flip = r_inj_pend ? (8'h01 << r_inj_pos) : 8'h00;

  // A pulse coinciding with a load is kept for the following load, since
  // the current load already consumed the previous pending value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inj_pend <= 1'b0;
      r_inj_pos  <= 3'd0;
    end else if (inj_valid) begin
      r_inj_pend <= 1'b1;
      r_inj_pos  <= inj_pos;
    end else if (w_accept | w_load_hi) begin
      r_inj_pend <= 1'b0;
    end
  end
`else
  assign w_flip = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hi_nib   <= 4'h0;
      r_out_data <= 8'h00;
      r_out_src  <= 1'b0;
      r_out_last <= 1'b0;
      r_last_src <= 1'b1;
    end else if (w_accept) begin
      r_hi_nib   <= w_sel[7:4];
      r_out_data <= enc(w_sel[3:0]) ^ w_flip;
      r_out_src  <= w_grant;
      r_out_last <= 1'b0;
      r_last_src <= w_grant;
    end else if (w_load_hi) begin
      r_out_data <= enc(r_hi_nib) ^ w_flip;
      r_out_last <= 1'b1;
    end
  end

  assign out_valid = (r_state != S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_hamming_byte_seq_arb.sv
// Purpose: directed table-driven bench for hamming_byte_seq_arb plus hand-written corner sequences.
// Latency: one table row per clock; inputs driven at negedge, outputs sampled 1ns later.
// Backpressure: rows hold out_ready low to exercise the stall path.
module tb_hamming_byte_seq_arb;

  logic       clk;
  logic       rst_n;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_src;
  logic       out_last;
  logic       out_ready;
  logic       busy;
`ifdef HAMENC_SEQ_ERRINJ_EN
  logic       inj_valid;
  logic [2:0] inj_pos;
`endif

  hamming_byte_seq_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_src    (out_src),
    .out_last   (out_last),
    .out_ready  (out_ready),
    .busy       (busy)
`ifdef HAMENC_SEQ_ERRINJ_EN
    ,
    .inj_valid  (inj_valid),
    .inj_pos    (inj_pos)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       r0v;
    logic [7:0] r0d;
    logic       r1v;
    logic [7:0] r1d;
    logic       ordy;
    logic       chk;
    logic       chk_dat;
    logic       e_r0rdy;
    logic       e_r1rdy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_src;
    logic       e_last;
    logic       e_busy;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp;
  int   n_err;

  task automatic add(input logic rs, input logic a_r0v, input logic [7:0] a_r0d,
                     input logic a_r1v, input logic [7:0] a_r1d, input logic a_ordy,
                     input logic a_chk, input logic a_chkd,
                     input logic e0, input logic e1, input logic eov, input logic [7:0] eod,
                     input logic esrc, input logic elast, input logic ebusy);
    vec_t v;
    v.rst_n = rs;  v.r0v = a_r0v; v.r0d = a_r0d; v.r1v = a_r1v; v.r1d = a_r1d;
    v.ordy = a_ordy; v.chk = a_chk; v.chk_dat = a_chkd;
    v.e_r0rdy = e0; v.e_r1rdy = e1; v.e_ov = eov; v.e_od = eod;
    v.e_src = esrc; v.e_last = elast; v.e_busy = ebusy;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got 0x%02h expected 0x%02h", name, row, act, exp);
    end
  endtask

  task automatic drive_idle();
    req0_valid = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_data = 8'h00;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive_idle();
`ifdef HAMENC_SEQ_ERRINJ_EN
    inj_valid = 1'b0;
    inj_pos   = 3'd0;
`endif

    //   rst r0v r0d   r1v r1d   ordy chk chkd r0r r1r ov  od    src last busy
    add(0, 0, 8'h00, 0, 8'h00, 0,  0, 0,  0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 0, 8'h00, 0, 8'h00, 0,  1, 1,  0, 0, 0, 8'h00, 0, 0, 0); // reset state
    add(1, 1, 8'hA5, 0, 8'h00, 1,  1, 0,  1, 0, 0, 8'h00, 0, 0, 0); // accept A5
    add(1, 0, 8'h00, 0, 8'h00, 1,  1, 1,  0, 0, 1, 8'h65, 0, 0, 1);
    add(1, 0, 8'h00, 0, 8'h00, 1,  1, 1,  0, 0, 1, 8'h1A, 0, 1, 1);
    add(1, 1, 8'hA5, 0, 8'h00, 1,  1, 0,  1, 0, 0, 8'h00, 0, 0, 0); // idle again, accept A5
    add(1, 0, 8'h00, 0, 8'h00, 1,  1, 1,  0, 0, 1, 8'h65, 0, 0, 1);
    add(0, 0, 8'h00, 0, 8'h00, 0,  1, 1,  0, 0, 1, 8'h1A, 0, 1, 1); // reset while in HI
    add(1, 1, 8'hA5, 1, 8'h3F, 1,  1, 1,  1, 0, 0, 8'h00, 0, 0, 0); // tie -> req0 after reset
    add(1, 1, 8'hA5, 1, 8'h3F, 1,  1, 1,  0, 0, 1, 8'h65, 0, 0, 1);
    add(1, 1, 8'hA5, 1, 8'h3F, 1,  1, 1,  0, 1, 1, 8'h1A, 0, 1, 1); // tie -> req1
    add(1, 1, 8'hA5, 1, 8'h3F, 1,  1, 1,  0, 0, 1, 8'h7F, 1, 0, 1);
    add(1, 1, 8'hA5, 1, 8'h3F, 1,  1, 1,  1, 0, 1, 8'h43, 1, 1, 1); // tie -> req0
    add(1, 1, 8'hA5, 1, 8'h3F, 1,  1, 1,  0, 0, 1, 8'h65, 0, 0, 1);
    add(1, 0, 8'h00, 1, 8'h3F, 1,  1, 1,  0, 1, 1, 8'h1A, 0, 1, 1); // accept 3F from req1
    for (int k = 0; k < 5; k++)
      add(1, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 0, 1, 8'h7F, 1, 0, 1); // stalled 5 cycles
    add(1, 0, 8'h00, 0, 8'h00, 1,  1, 1,  0, 0, 1, 8'h7F, 1, 0, 1); // ready rises
    add(1, 0, 8'h00, 0, 8'h00, 1,  1, 1,  0, 0, 1, 8'h43, 1, 1, 1);
    add(1, 0, 8'h00, 1, 8'h3F, 1,  1, 0,  0, 1, 0, 8'h00, 0, 0, 0); // req1 only, last_src=1
    add(1, 0, 8'h00, 1, 8'h3F, 1,  1, 1,  0, 0, 1, 8'h7F, 1, 0, 1); // no ready in LO
    add(1, 0, 8'h00, 1, 8'h3F, 1,  1, 1,  0, 1, 1, 8'h43, 1, 1, 1);
    add(1, 0, 8'h00, 1, 8'h3F, 1,  1, 1,  0, 0, 1, 8'h7F, 1, 0, 1);
    add(1, 0, 8'h00, 1, 8'h3F, 1,  1, 1,  0, 1, 1, 8'h43, 1, 1, 1);
    add(1, 0, 8'h00, 1, 8'h3F, 1,  1, 1,  0, 0, 1, 8'h7F, 1, 0, 1);
    add(1, 1, 8'hA5, 1, 8'h3F, 1,  1, 1,  1, 0, 1, 8'h43, 1, 1, 1); // tie -> req0
    add(1, 0, 8'h00, 0, 8'h00, 1,  1, 1,  0, 0, 1, 8'h65, 0, 0, 1);
    add(1, 0, 8'h00, 0, 8'h00, 1,  1, 1,  0, 0, 1, 8'h1A, 0, 1, 1);
    add(1, 1, 8'h96, 0, 8'h00, 1,  1, 0,  1, 0, 0, 8'h00, 0, 0, 0); // accept 96
    add(1, 0, 8'hFF, 0, 8'h00, 1,  1, 1,  0, 0, 1, 8'h26, 0, 0, 1); // source data changes
    add(1, 0, 8'hFF, 0, 8'h00, 1,  1, 1,  0, 0, 1, 8'h59, 0, 1, 1);
    add(1, 0, 8'h00, 0, 8'h00, 1,  1, 0,  0, 0, 0, 8'h00, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n      = tbl[i].rst_n;
      req0_valid = tbl[i].r0v;
      req0_data  = tbl[i].r0d;
      req1_valid = tbl[i].r1v;
      req1_data  = tbl[i].r1d;
      out_ready  = tbl[i].ordy;
      #1;
      if (tbl[i].chk) begin
        cmp("req0_ready", i, {7'd0, req0_ready}, {7'd0, tbl[i].e_r0rdy});
        cmp("req1_ready", i, {7'd0, req1_ready}, {7'd0, tbl[i].e_r1rdy});
        cmp("out_valid",  i, {7'd0, out_valid},  {7'd0, tbl[i].e_ov});
        cmp("busy",       i, {7'd0, busy},       {7'd0, tbl[i].e_busy});
        if (tbl[i].chk_dat) begin
          cmp("out_data", i, out_data,           tbl[i].e_od);
          cmp("out_src",  i, {7'd0, out_src},    {7'd0, tbl[i].e_src});
          cmp("out_last", i, {7'd0, out_last},   {7'd0, tbl[i].e_last});
        end
      end
    end

    // Single byte 0x5A, then bounded wait for the low codeword.
    begin
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      req0_valid = 1'b1; req0_data = 8'h5A; out_ready = 1'b1;
      @(negedge clk);
      drive_idle();
      for (int c = 0; c < 8 && !seen; c++) begin
        #1;
        if (out_valid) seen = 1'b1;
        else @(negedge clk);
      end
      if (!seen) begin
        n_cmp++; n_err++;
        $display("FAIL wait_5A: out_valid never rose within 8 cycles");
      end else begin
        cmp("seq_5A_lo", 100, out_data, 8'h1A);
        @(negedge clk); #1;
        cmp("seq_5A_hi", 101, out_data, 8'h65);
        cmp("seq_5A_last", 101, {7'd0, out_last}, 8'h01);
        @(negedge clk); #1;
        cmp("seq_5A_idle", 102, {7'd0, busy}, 8'h00);
      end
    end

`ifdef HAMENC_SEQ_ERRINJ_EN
    // Arm a flip of bit 7 in IDLE; only the first codeword of the next byte is hit.
    @(negedge clk);
    inj_valid = 1'b1; inj_pos = 3'd7; out_ready = 1'b1;
    @(negedge clk);
    inj_valid = 1'b0; inj_pos = 3'd0;
    req0_valid = 1'b1; req0_data = 8'hA5;
    @(negedge clk);
    drive_idle();
    #1;
    cmp("inj_lo", 200, out_data, 8'hE5);
    @(negedge clk); #1;
    cmp("inj_hi", 201, out_data, 8'h1A);
    @(negedge clk); #1;
    cmp("inj_idle", 202, {7'd0, busy}, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hamming_byte_seq_arb.md
# hamming_byte_seq_arb

Two-requester front end for the team's 4-bit Hamming encoder. Each requester offers whole data bytes over a valid/ready handshake. A round-robin arbiter grants one requester at a time. The accepted byte is split into low and high nibbles, and each nibble's 8-bit codeword is emitted in order on one valid/ready output stream tagged with its source. The block sits between the packet/byte producers and the line serializer.

## Interface
Parameters: none (widths fixed by the 4-bit encoder).
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  8  requester 0 byte
- req0_ready  out  1  requester 0 byte accepted this cycle
- req1_valid  in  1  requester 1 has a byte
- req1_data  in  8  requester 1 byte
- req1_ready  out  1  requester 1 byte accepted this cycle
- out_valid  out  1  codeword available
- out_data  out  8  codeword (registered)
- out_src  out  1  requester that supplied the byte
- out_last  out  1  1 = high-nibble codeword (second of pair)
- out_ready  in  1  downstream accepts codeword
- busy  out  1  state != IDLE
- inj_valid  in  1  (only with HAMENC_SEQ_ERRINJ_EN) arm single-bit error
- inj_pos  in  3  (only with HAMENC_SEQ_ERRINJ_EN) bit index to flip

## Operation
- Codeword for nibble d: c0=d0, c1=d1, c2=d2, c3=d0^d1^d2, c4=d3, c5=d0^d1^d3, c6=d1^d2^d3, c7=d0^d1^d2^d3.
- FSM states are IDLE, LO and HI.
  - IDLE: out_valid=0. When any req valid, grant and accept. Load out_data=enc(byte[3:0]), out_src=grantee, out_last=0. Go to LO.
  - LO: out_valid=1. On out_ready, load out_data=enc(byte[7:4]) and out_last=1, then go to HI. Otherwise hold all outputs stable.
  - HI: out_valid=1. On out_ready: if any req is valid, accept a new byte in the same cycle and go to LO. Otherwise go to IDLE.
- Accept condition: (state==IDLE) | (state==HI & out_ready). reqN_ready = accept condition & grant==N & reqN_valid. At most one ready per cycle.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester other than last_src wins.
  - last_src updates only on accept.
- Captured byte is held internally; req data may change after acceptance.
- Downstream backpressure is unbounded; outputs are held stable while out_valid & !out_ready.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, out_valid=0, out_data=0x00, out_src=0, out_last=0, busy=0, last_src=1 (requester 0 wins the first tie), injection pending cleared.
  - Reset mid-pair discards the remaining codeword.
- Latency: byte accepted at edge N, so its low codeword is valid in cycle N+1.
- Throughput: with out_ready held high, one byte per 2 cycles. Pairs are never interleaved across sources.
- reqN_ready is combinational from reqN_valid, state, out_ready and last_src. It must not feed back from the requester.
- A simultaneous out_ready in HI and a new req valid gives back-to-back operation with no IDLE bubble.

## Configuration
- Macro: HAMENC_SEQ_ERRINJ_EN.
- Defined:
  - Ports inj_valid and inj_pos exist.
  - An inj_valid pulse sets a pending flag and latches inj_pos. A later pulse before use overwrites it.
  - The next codeword loaded into out_data is XORed with (1<<pos), then the pending flag clears.
  - If inj_valid arrives in the same cycle as a load, it applies to the following load.
- Undefined: ports absent, no pending logic, out_data always the clean codeword.

## Test plan
- Reset, then req0 byte 0xA5 with out_ready=1 -> req0_ready at edge 0; out_data=0x65 (src0,last0) cycle 1, 0x1A (src0,last1) cycle 2, busy=0 cycle 3.
- Both requesters valid continuously (req0=0xA5, req1=0x3F), out_ready=1 -> pairs alternate src0,src1,src0: 0x65,0x1A,0x7F,0x43,… with no idle cycles.
- Byte 0x3F with out_ready=0 for 5 cycles after acceptance -> out_data holds 0x7F and out_last=0 throughout, then 0x43 one cycle after out_ready rises.
- Assert rst_n=0 while in HI with 0x1A pending -> next cycle out_valid=0, busy=0; subsequent tie is granted to req0.
- Only req1 valid for 3 bytes -> all granted to req1 despite last_src=1; then a tie is granted to req0.
- (HAMENC_SEQ_ERRINJ_EN) inj_valid with inj_pos=7 in IDLE, then byte 0xA5 -> codewords 0xE5 then 0x1A (single injection only).
